// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: FSM state encoding,
// seven-segment glyphs (gfedcba, active-high) and a saturating increment.
package score_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [6:0] SEG_0 = 7'h3F;
   localparam logic [6:0] SEG_1 = 7'h06;
   localparam logic [6:0] SEG_2 = 7'h5B;
   localparam logic [6:0] SEG_3 = 7'h4F;
   localparam logic [6:0] SEG_4 = 7'h66;
   localparam logic [6:0] SEG_5 = 7'h6D;
   localparam logic [6:0] SEG_6 = 7'h7D;
   localparam logic [6:0] SEG_7 = 7'h07;
   localparam logic [6:0] SEG_8 = 7'h7F;
   localparam logic [6:0] SEG_9 = 7'h6F;
   localparam logic [6:0] SEG_A = 7'h77;
   localparam logic [6:0] SEG_B = 7'h7C;
   localparam logic [6:0] SEG_C = 7'h39;
   localparam logic [6:0] SEG_D = 7'h5E;
   localparam logic [6:0] SEG_E = 7'h79;
   localparam logic [6:0] SEG_F = 7'h71;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Counters stick at 15 instead of wrapping.
   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex digit to seven-segment glyph (gfedcba, active-high).
// Purely combinational, no latency; no flow control.
module seg7_decode
   import score_pkg::*;
(
   input  logic [3:0] value,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_F;
      case (value)
         4'h0:    seg = SEG_0;
         4'h1:    seg = SEG_1;
         4'h2:    seg = SEG_2;
         4'h3:    seg = SEG_3;
         4'h4:    seg = SEG_4;
         4'h5:    seg = SEG_5;
         4'h6:    seg = SEG_6;
         4'h7:    seg = SEG_7;
         4'h8:    seg = SEG_8;
         4'h9:    seg = SEG_9;
         4'hA:    seg = SEG_A;
         4'hB:    seg = SEG_B;
         4'hC:    seg = SEG_C;
         4'hD:    seg = SEG_D;
         4'hE:    seg = SEG_E;
         default: seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/score_keeper.sv
// Game score keeper: counts correct/incorrect result edges per game, tracks best score, drives a blinking 7-seg.
// Counters update one clock after a result edge; no backpressure, result lights are level inputs sampled every cycle.
module score_keeper
   import score_pkg::*;
#(
   parameter int NUM_ROUNDS   = 8,
   parameter int BLINK_CYCLES = 16
)(
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       correct_in,
   input  logic       incorrect_in,
   output logic [3:0] score,
   output logic [3:0] rounds,
   output logic [3:0] streak,
   output logic [3:0] best_score,
   output logic       game_over,
   output logic [6:0] seg
);

   localparam logic [3:0]  LAST_ROUND = 4'(NUM_ROUNDS);
   localparam logic [15:0] BLINK_LAST = 16'(BLINK_CYCLES - 1);

   state_t      state, state_nxt;
   logic        correct_q, incorrect_q;
   logic        rise_c, rise_i;
   logic        hit_c, hit_i, result, finishing;
   logic [3:0]  rounds_nxt, score_nxt;
   logic [15:0] blink_cnt;
   logic        blank;
   logic [3:0]  disp_val;
   logic [6:0]  glyph;

   assign rise_c = correct_in & ~correct_q;
   assign rise_i = incorrect_in & ~incorrect_q;

   // A simultaneous rise on both lights counts as a single incorrect round.
   assign hit_i  = rise_i & (state == PLAY) & ~start;
   assign hit_c  = rise_c & ~rise_i & (state == PLAY) & ~start;
   assign result = hit_c | hit_i;

   assign rounds_nxt = sat_inc(rounds);
   assign score_nxt  = hit_c ? sat_inc(score) : score;
   assign finishing  = result && (rounds_nxt == LAST_ROUND);

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = PLAY;
      end else if (state == PLAY && finishing) begin
         state_nxt = DONE;
      end
   end

   // History follows the lights even through start, so a light already high
   // when start is released is not mistaken for a fresh result.
   always_ff @(posedge clock) begin
      if (reset) begin
         correct_q   <= 1'b0;
         incorrect_q <= 1'b0;
      end else begin
         correct_q   <= correct_in;
         incorrect_q <= incorrect_in;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         score      <= 4'd0;
         rounds     <= 4'd0;
         streak     <= 4'd0;
         best_score <= 4'd0;
      end else if (start) begin
         score  <= 4'd0;
         rounds <= 4'd0;
         streak <= 4'd0;
      end else if (result) begin
         rounds <= rounds_nxt;
         score  <= score_nxt;
         streak <= hit_c ? sat_inc(streak) : 4'd0;
         if (finishing && (score_nxt > best_score)) begin
            best_score <= score_nxt;
         end
      end
   end

   // Blink timer idles at zero outside DONE so the first DONE cycle shows the score.
   always_ff @(posedge clock) begin
      if (reset || state != DONE) begin
         blink_cnt <= 16'd0;
         blank     <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt <= 16'd0;
         blank     <= ~blank;
      end else begin
         blink_cnt <= blink_cnt + 16'd1;
      end
   end

   assign disp_val = (state == IDLE) ? best_score : score;

   seg7_decode u_seg7_decode (
      .value (disp_val),
      .seg   (glyph)
   );

   assign seg       = (state == DONE && blank) ? SEG_BLANK : glyph;
   assign game_over = (state == DONE);

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: stimulus queues hand-computed snapshots,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_score_keeper;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       correct_in = 1'b0;
   logic       incorrect_in = 1'b0;
   logic [3:0] score, rounds, streak, best_score;
   logic       game_over;
   logic [6:0] seg;

   typedef struct {
      string      name;
      logic [3:0] sc;
      logic [3:0] rd;
      logic [3:0] st;
      logic [3:0] bs;
      logic       go;
      logic [6:0] sg;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   passes = 0;

   score_keeper #(.NUM_ROUNDS(8), .BLINK_CYCLES(16)) dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .correct_in   (correct_in),
      .incorrect_in (incorrect_in),
      .score        (score),
      .rounds       (rounds),
      .streak       (streak),
      .best_score   (best_score),
      .game_over    (game_over),
      .seg          (seg)
   );

   initial forever #5 clock = ~clock;

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic expect_out(input string name, input int sc, input int rd, input int st,
                             input int bs, input bit go, input logic [6:0] sg);
      exp_t e;
      e.name = name;
      e.sc = 4'(sc); e.rd = 4'(rd); e.st = 4'(st); e.bs = 4'(bs);
      e.go = go; e.sg = sg;
      sb.push_back(e);
   endtask

   // 10-cycle result pulse followed by a 5-cycle gap.
   task automatic pulse(input bit c, input bit i);
      correct_in = c; incorrect_in = i;
      step(10);
      correct_in = 1'b0; incorrect_in = 1'b0;
      step(5);
   endtask

   // Monitor: compares each queued snapshot at the falling edge.
   always @(negedge clock) begin
      while (sb.size() > 0) begin
         mon_e = sb.pop_front();
         checks++;
         if ({score, rounds, streak, best_score, game_over, seg} ===
             {mon_e.sc, mon_e.rd, mon_e.st, mon_e.bs, mon_e.go, mon_e.sg}) begin
            passes++;
         end else begin
            $display("FAIL %s: got score=%0d rounds=%0d streak=%0d best=%0d go=%0b seg=%h, want score=%0d rounds=%0d streak=%0d best=%0d go=%0b seg=%h",
                     mon_e.name, score, rounds, streak, best_score, game_over, seg,
                     mon_e.sc, mon_e.rd, mon_e.st, mon_e.bs, mon_e.go, mon_e.sg);
         end
      end
   end

   localparam logic [6:0] G0 = 7'h3F, G1 = 7'h06, G2 = 7'h5B, G5 = 7'h6D, G8 = 7'h7F, GOFF = 7'h00;
   localparam logic [6:0] GLYPH [8] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07};

   initial begin
      // Reset, then idle.
      step(2);
      reset = 1'b0;
      step(5);
      expect_out("idle_after_reset", 0, 0, 0, 0, 0, G0);

      // Eight correct rounds.
      start = 1'b1; step(1); start = 1'b0;
      expect_out("start_a", 0, 0, 0, 0, 0, G0);
      for (int k = 1; k <= 8; k++) begin
         pulse(1'b1, 1'b0);
         if (k < 8) expect_out($sformatf("allc_round%0d", k), k, k, k, 0, 0, GLYPH[k]);
      end
      expect_out("allc_done_idx14", 8, 8, 8, 8, 1, G8);
      step(1);
      expect_out("blink_idx15_on", 8, 8, 8, 8, 1, G8);
      step(1);
      expect_out("blink_idx16_off", 8, 8, 8, 8, 1, GOFF);
      step(15);
      expect_out("blink_idx31_off", 8, 8, 8, 8, 1, GOFF);
      step(1);
      expect_out("blink_idx32_on", 8, 8, 8, 8, 1, G8);

      // Mixed pattern C,C,I,C,C,C,I,I.
      start = 1'b1; step(1); start = 1'b0;
      expect_out("start_b_keeps_best", 0, 0, 0, 8, 0, G0);
      pulse(1, 0); pulse(1, 0); pulse(0, 1);
      pulse(1, 0); pulse(1, 0); pulse(1, 0);
      expect_out("mix_before_round7", 5, 6, 3, 8, 0, G5);
      pulse(0, 1); pulse(0, 1);
      expect_out("mix_done", 5, 8, 0, 8, 1, G5);

      // Simultaneous rises count as one incorrect round.
      start = 1'b1; step(1); start = 1'b0;
      pulse(1, 0);
      expect_out("sim_pre", 1, 1, 1, 8, 0, G1);
      pulse(1, 1);
      expect_out("sim_both", 1, 2, 0, 8, 0, G1);

      // Restart mid-game with correct_in held across start release.
      pulse(1, 0);
      expect_out("mid_round3", 2, 3, 1, 8, 0, G2);
      correct_in = 1'b1; start = 1'b1;
      step(2);
      expect_out("mid_start_clear", 0, 0, 0, 8, 0, G0);
      start = 1'b0;
      step(5);
      expect_out("mid_held_not_counted", 0, 0, 0, 8, 0, G0);
      correct_in = 1'b0; step(2);
      correct_in = 1'b1; step(1);
      expect_out("mid_fresh_edge", 1, 1, 1, 8, 0, G1);
      step(9);
      correct_in = 1'b0; step(5);

      // Finish the game, confirm DONE ignores results, then reset wins.
      for (int k = 0; k < 7; k++) pulse(1, 0);
      expect_out("final_done", 8, 8, 8, 8, 1, G8);
      pulse(0, 1);
      expect_out("done_ignores_result", 8, 8, 8, 8, 1, GOFF);
      reset = 1'b1; start = 1'b1; correct_in = 1'b1;
      step(1);
      expect_out("reset_beats_start", 0, 0, 0, 0, 0, G0);
      reset = 1'b0; start = 1'b0; correct_in = 1'b0;
      step(3);
      expect_out("idle_after_reset2", 0, 0, 0, 0, 0, G0);

      step(2);
      checks++;
      if (sb.size() == 0) passes++;
      else $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
